mul_pipe_acc: RTL and testbench
===============================

# mul_pipe_acc

Parametrised pipelined multiplier with a valid qualifier, global clock enable, per-sample signed/unsigned mode and an optional multiply-accumulate output. It is the next generation of the fixed unsigned registered-operand multiplier used in our Xilinx DSP-inference tests. Its register structure (input register, product register, post-product pipeline) is shaped so synthesis can absorb it into DSP48 A/B, M and P registers.

## Interface
- WIDTHA, 6, width of operand A
- WIDTHB, 9, width of operand B
- STAGES, 4, product registers after the multiply, including the first (M[0]); legal range 1..8
- ACCW, WIDTHA+WIDTHB+4, accumulator width; must be >= WIDTHA+WIDTHB
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; 0 freezes every register, including valid bits and accumulator
- in_valid  in  1  A/B/sgn/clr_acc qualify a sample this cycle
- sgn  in  1  1 = A and B are two's complement; 0 = both unsigned
- clr_acc  in  1  sample starts a new accumulation
- A  in  WIDTHA  operand A
- B  in  WIDTHB  operand B
- out_valid  out  1  RES (and ACC) updated by a valid sample this cycle
- RES  out  WIDTHA+WIDTHB  exact product of the emerging sample
- ACC  out  ACCW  running accumulation
- acc_ovf  out  1  sticky accumulator overflow

## Operation
- Stage 0: rA, rB, rsgn, rclr and rvalid capture the inputs when ce=1. Invalid samples still flow, but their valid bit is 0.
- Stage 1: M[0] gets the full-width product of rA and rB.
  - rsgn=1: signed multiply.
  - rsgn=0: unsigned multiply.
  - The result is exact in WIDTHA+WIDTHB bits, with no truncation.
- Stages 2..STAGES: M[i] <= M[i-1]. The valid, sgn and clr sideband bits shift alongside the data.
- RES = M[STAGES]. out_valid is that stage's valid bit. RES holds its last value when out_valid=0. RES does not reflect invalid samples, which do not overwrite the output register.
- Accumulator (macro enabled): when a sample exits with valid=1 and ce=1:
  - ext(RES) is RES sign-extended to ACCW if the sample's sgn=1, else zero-extended.
  - If the sample's clr=1: ACC <= ext(RES) and acc_ovf <= 0.
  - Otherwise: ACC <= ACC + ext(RES), wrapping modulo 2^ACCW.
  - acc_ovf is set on overflow and stays set until the next clr sample or rst. Overflow is judged using the sample's own sgn:
    - unsigned: carry out of bit ACCW-1;
    - signed: both addends share a sign bit and the sum's sign differs.
- Mixed sgn across samples is legal. Each addition uses the current sample's sgn.
- Reset: all data registers, valid bits, RES, ACC and acc_ovf clear to 0; out_valid=0. Reset takes priority over ce. In-flight samples are discarded, and the first sample after reset needs a full latency.

## Timing
- Latency: a sample presented with in_valid=1 at rising edge n (ce=1 throughout) appears on RES with out_valid=1 after edge n+STAGES+1. Default STAGES=4 gives a latency of 5.
- ACC reflects that same sample after the same edge. There is no extra accumulator cycle: the addition is combinational into the ACC register at the final stage.
- Throughput: one sample per enabled cycle. There is no backpressure; the consumer must accept out_valid.
- ce=0 cycles: latency is counted in ce=1 edges only. out_valid stays at its current value during ce=0, so the consumer qualifies it with ce.
- in_valid with ce=0 is ignored; the sample is lost.
- Outputs are registered only. There is no combinational path from any input to any output.

## Configuration
- MUL_PIPE_ACC_EN defined:
  - Accumulator and overflow logic are built as described above.
  - clr_acc sideband registers exist.
- MUL_PIPE_ACC_EN undefined:
  - No accumulator or sideband logic.
  - ACC is tied to 0 and acc_ovf to 0.
  - clr_acc is ignored.
  - RES/out_valid behaviour and latency are unchanged.

## Test plan
- Unsigned, default parameters: A=6'h3F, B=9'h1FF, sgn=0, one valid cycle. Expect RES=15'h7DC1 (32193) with out_valid=1 exactly 5 edges later, and out_valid=0 on every other cycle.
- Signed vs unsigned: A=6'h20, B=9'h001.
  - sgn=1 gives RES=15'h7FE0 (-32).
  - Same operands with sgn=0 gives RES=15'h0020.
  - A=6'h3F, B=9'h1FF, sgn=1 gives RES=15'h0001.
  - Send all three back-to-back; expect three consecutive out_valid cycles in order.
- Stall: issue a sample, then drop ce for 3 cycles mid-pipe. Expect RES and out_valid frozen, and the result emerging after 5 enabled edges in total. A sample presented with ce=0 never emerges.
- Reset mid-flight: issue 3 samples, then assert rst for 1 cycle after 2 edges. Expect out_valid=0 and RES=ACC=0 on the cycle after reset, and none of the 3 samples emerging.
- Accumulate (MUL_PIPE_ACC_EN): four unsigned samples 63*511, the first with clr_acc=1. Expect ACC=19'h1F704 (128772) and acc_ovf=0.
- Overflow (MUL_PIPE_ACC_EN): continue the accumulate scenario to 17 samples in total. Expect ACC=22993 and acc_ovf=1 sticky. A following clr sample 1*1 gives ACC=1 and acc_ovf=0.

Source files
------------

// File: rtl/mul_pipe_acc.sv
// Pipelined signed/unsigned multiplier, optional multiply-accumulate when MUL_PIPE_ACC_EN is defined.
// Latency: STAGES+1 enabled edges from input capture to RES/ACC.
// Backpressure: none; ce=0 freezes every register, and the consumer must take every out_valid.
module mul_pipe_acc #(
  parameter int WIDTHA = 6,
  parameter int WIDTHB = 9,
  parameter int STAGES = 4,
  parameter int ACCW   = WIDTHA + WIDTHB + 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic                     sgn,
  input  logic                     clr_acc,
  input  logic [WIDTHA-1:0]        A,
  input  logic [WIDTHB-1:0]        B,
  output logic                     out_valid,
  output logic [WIDTHA+WIDTHB-1:0] RES,
  output logic [ACCW-1:0]          ACC,
  output logic                     acc_ovf
);

  localparam int PW = WIDTHA + WIDTHB;

  // Stage 0: operand registers (DSP A/B regs)
  logic [WIDTHA-1:0] ra_q, ra_d;
  logic [WIDTHB-1:0] rb_q, rb_d;
  logic              rsgn_q, rsgn_d;
  logic              rvalid_q, rvalid_d;

  // Product pipeline (M regs then P reg)
  logic [STAGES-1:0][PW-1:0] m_q, m_d;
  logic [STAGES-1:0]         mv_q, mv_d;
  logic [PW-1:0]             a_ext, b_ext, prod;
  logic [PW-1:0]             res_q, res_d;
  logic                      out_valid_q, out_valid_d;
  logic [PW-1:0]             tail_dat;
  logic                      tail_vld;

  always_comb begin
    ra_d     = ra_q;
    rb_d     = rb_q;
    rsgn_d   = rsgn_q;
    rvalid_d = rvalid_q;
    if (ce) begin
      ra_d     = A;
      rb_d     = B;
      rsgn_d   = sgn;
      rvalid_d = in_valid;
    end
  end

  // Extending both operands to the full product width makes the truncated multiply exact.
  always_comb begin
    a_ext = rsgn_q ? PW'($signed(ra_q)) : PW'(ra_q);
    b_ext = rsgn_q ? PW'($signed(rb_q)) : PW'(rb_q);
    prod  = a_ext * b_ext;
  end

  always_comb begin
    m_d  = m_q;
    mv_d = mv_q;
    if (ce) begin
      m_d[0]  = prod;
      mv_d[0] = rvalid_q;
      for (int i = 1; i < STAGES; i++) begin
        m_d[i]  = m_q[i-1];
        mv_d[i] = mv_q[i-1];
      end
    end
  end

  assign tail_dat = m_q[STAGES-1];
  assign tail_vld = mv_q[STAGES-1];

  always_comb begin
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (ce) begin
      out_valid_d = tail_vld;
      if (tail_vld) res_d = tail_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q        <= '0;
      rb_q        <= '0;
      rsgn_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      m_q         <= '0;
      mv_q        <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rsgn_q      <= rsgn_d;
      rvalid_q    <= rvalid_d;
      m_q         <= m_d;
      mv_q        <= mv_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign RES       = res_q;
  assign out_valid = out_valid_q;

`ifdef MUL_PIPE_ACC_EN
  // sgn/clr ride alongside the product so each sample is accumulated with its own mode.
  logic              rclr_q, rclr_d;
  logic [STAGES-1:0] ms_q, ms_d;
  logic [STAGES-1:0] mc_q, mc_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [ACCW-1:0]   ext;
  logic [ACCW:0]     sum;
  logic              ovf_now;

  always_comb begin
    rclr_d = rclr_q;
    ms_d   = ms_q;
    mc_d   = mc_q;
    if (ce) begin
      rclr_d  = clr_acc;
      ms_d[0] = rsgn_q;
      mc_d[0] = rclr_q;
      for (int i = 1; i < STAGES; i++) begin
        ms_d[i] = ms_q[i-1];
        mc_d[i] = mc_q[i-1];
      end
    end
  end

  always_comb begin
    ext     = ms_q[STAGES-1] ? ACCW'($signed(tail_dat)) : ACCW'(tail_dat);
    sum     = {1'b0, acc_q} + {1'b0, ext};
    ovf_now = ms_q[STAGES-1]
            ? ((acc_q[ACCW-1] == ext[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1]))
            : sum[ACCW];
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (ce && tail_vld) begin
      if (mc_q[STAGES-1]) begin
        acc_d = ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum[ACCW-1:0];
        ovf_d = ovf_q | ovf_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rclr_q <= 1'b0;
      ms_q   <= '0;
      mc_q   <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      rclr_q <= rclr_d;
      ms_q   <= ms_d;
      mc_q   <= mc_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ACC     = acc_q;
  assign acc_ovf = ovf_q;
`else
  logic unused_clr;
  assign unused_clr = clr_acc;
  assign ACC        = '0;
  assign acc_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_mul_pipe_acc.sv
// Directed self-checking bench for mul_pipe_acc at default parameters.
module tb_mul_pipe_acc;

`ifdef MUL_PIPE_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        sgn = 1'b0;
  logic        clr_acc = 1'b0;
  logic [5:0]  a_in = '0;
  logic [8:0]  b_in = '0;
  logic        out_valid;
  logic [14:0] res;
  logic [18:0] acc;
  logic        acc_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  mul_pipe_acc dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .sgn       (sgn),
    .clr_acc   (clr_acc),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .RES       (res),
    .ACC       (acc),
    .acc_ovf   (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [8:0] b,
                       input logic s, input logic c);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    sgn      = s;
    clr_acc  = c;
  endtask

  function automatic logic [18:0] acc_exp(input logic [18:0] v);
    return ACC_ON ? v : 19'd0;
  endfunction

  initial begin
    int cnt;
    step();
    step();
    rst = 1'b0;
    chk("rst_ovld", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", acc_ovf, 0);

    // Unsigned max x max: out_valid only on the 5th edge after capture
    drive(1, 6'h3F, 9'h1FF, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("u_ovld_%0d", k), out_valid, (k == 5));
    end
    chk("u_res", res, 15'h7DC1);
    chk("u_acc", acc, acc_exp(19'd32193));
    step();
    chk("u_ovld_after", out_valid, 0);
    chk("u_res_hold", res, 15'h7DC1);

    // Signed vs unsigned, back to back
    drive(1, 6'h20, 9'h001, 1, 1); step();
    drive(1, 6'h20, 9'h001, 0, 1); step();
    drive(1, 6'h3F, 9'h1FF, 1, 1); step();
    drive(0, 0, 0, 0, 0);
    step(); step();
    chk("s_ovld_pre", out_valid, 0);
    step();
    chk("s_ovld0", out_valid, 1);
    chk("s_res0", res, 15'h7FE0);
    chk("s_acc0", acc, acc_exp(19'h7FFE0));
    step();
    chk("s_ovld1", out_valid, 1);
    chk("s_res1", res, 15'h0020);
    step();
    chk("s_ovld2", out_valid, 1);
    chk("s_res2", res, 15'h0001);
    chk("s_acc2", acc, acc_exp(19'd1));
    step();
    chk("s_ovld_end", out_valid, 0);

    // Stall: 5*7 needs 5 enabled edges; a sample offered with ce=0 is lost
    drive(1, 6'd5, 9'd7, 0, 1); step();
    drive(0, 0, 0, 0, 0);
    step(); step();
    ce = 1'b0;
    drive(1, 6'd9, 9'd9, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("st_ovld_frz%0d", k), out_valid, 0);
      chk($sformatf("st_res_frz%0d", k), res, 15'h0001);
    end
    ce = 1'b1;
    drive(0, 0, 0, 0, 0);
    step(); step();
    chk("st_ovld_pre", out_valid, 0);
    step();
    chk("st_ovld", out_valid, 1);
    chk("st_res", res, 15'd35);
    chk("st_acc", acc, acc_exp(19'd35));
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) cnt++;
    end
    chk("st_lost_sample", cnt, 0);
    chk("st_res_final", res, 15'd35);

    // Reset mid-flight discards everything in the pipe
    drive(1, 6'd3, 9'd3, 0, 1); step();
    drive(1, 6'd4, 9'd4, 0, 0); step();
    drive(1, 6'd5, 9'd5, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_ovld", out_valid, 0);
    chk("rm_res", res, 0);
    chk("rm_acc", acc, 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (out_valid) cnt++;
    end
    chk("rm_none_emerge", cnt, 0);

    // Accumulate 17 x 63*511 unsigned: overflow past 2^19 on the 17th
    cnt = 0;
    for (int t = 0; t < 26; t++) begin
      if (t < 17) drive(1, 6'h3F, 9'h1FF, 0, (t == 0));
      else        drive(0, 0, 0, 0, 0);
      step();
      if (out_valid) begin
        cnt++;
        if (cnt == 4) begin
          chk("ac4_acc", acc, acc_exp(19'h1F704));
          chk("ac4_ovf", acc_ovf, 0);
        end
        if (cnt == 16) begin
          chk("ac16_acc", acc, acc_exp(19'd515088));
          chk("ac16_ovf", acc_ovf, 0);
        end
        if (cnt == 17) begin
          chk("ac17_acc", acc, acc_exp(19'd22993));
          chk("ac17_ovf", acc_ovf, ACC_ON);
        end
      end
    end
    chk("ac_count", cnt, 17);

    // Sticky overflow survives a non-clear sample, cleared by a clr sample
    drive(1, 6'd1, 9'd1, 0, 0); step();
    drive(1, 6'd1, 9'd1, 0, 1); step();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step();
    chk("sticky_acc", acc, acc_exp(19'd22994));
    chk("sticky_ovf", acc_ovf, ACC_ON);
    step();
    chk("clr_res", res, 15'd1);
    chk("clr_acc", acc, acc_exp(19'd1));
    chk("clr_ovf", acc_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
